seg7_disp_sched: RTL

Display scheduler in front of the 4-digit 7-segment decoder. It shares the display between two requesters. Source A is the live 6-digit BCD measurement, autoranged to a 4-digit window with hysteresis and refreshed at a fixed cadence. Source B is a priority 4-digit message held for a fixed time. The block also applies blink blanking and leading-zero blanking; the downstream decoder only converts BCD to segments and honours `disp_blank`.

---
 rtl/seg7_disp_sched.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_disp_sched.sv
// -----------------------------------------------------------------------------
// seg7_disp_sched
//
// Display scheduler in front of a 4-digit 7-segment decoder. Two requesters
// share the display:
//   * source A: a live 6-digit BCD measurement. It is snapshotted at a fixed
//     tick cadence and autoranged into a 4-digit window, with hysteresis on
//     down-ranging. Leading-zero blanking is optional.
//   * source B: a priority 4-digit message. It is held on the display for a
//     fixed number of ticks and can be retriggered.
// Blink blanking is applied on top of either source. The downstream decoder
// only converts BCD to segments and honours disp_blank.
//
// Timing: there are two register stages. Stage 1 holds the FSM, latched data
// and counters. Stage 2 holds the output registers. An input event sampled in
// cycle n is visible on the outputs in cycle n+2. The exception is b_ack, which
// is registered straight from the request and appears in cycle n+1.
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   synchronous, active-high reset
//   tick_1ms   in   1   one-clk pulse every 1 ms
//   a_val      in  20   binary value of source A, used for ranging
//   a_bcd      in  24   source A BCD digits, [3:0] ones .. [23:20] 1e5
//   b_req      in   1   one-clk request to show source B
//   b_bcd      in  16   source B digits, sampled with b_req
//   blink_en   in   1   level, enables blinking
//   disp_bcd   out 16   digits to the decoder, [3:0] rightmost
//   disp_blank out  4   per-digit blank, 1 = digit off
//   range_led  out  3   one-hot range: [0] x1, [1] x10, [2] x100
//   b_active   out  1   source B is on the display
//   b_ack      out  1   one-clk pulse when b_req is accepted
//   upd_strobe out  1   one-clk pulse when a snapshot reaches the outputs
// -----------------------------------------------------------------------------
module seg7_disp_sched #(
    parameter int UPD_MS       = 250,
    parameter int HOLD_MS      = 2000,
    parameter int HYST         = 500,
    parameter int BLINK_PER_MS = 1000,
    parameter int BLINK_OFF_MS = 200,
    parameter int LZB          = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1ms,
    input  logic [19:0] a_val,
    input  logic [23:0] a_bcd,
    input  logic        b_req,
    input  logic [15:0] b_bcd,
    input  logic        blink_en,
    output logic [15:0] disp_bcd,
    output logic [3:0]  disp_blank,
    output logic [2:0]  range_led,
    output logic        b_active,
    output logic        b_ack,
    output logic        upd_strobe
);

    localparam int UPD_W   = (UPD_MS > 1) ? $clog2(UPD_MS) : 1;
    localparam int HOLD_W  = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
    localparam int BLINK_W = $clog2(BLINK_PER_MS);

    localparam logic [UPD_W-1:0]   UPD_LAST   = UPD_W'(UPD_MS - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_MS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PER_MS - 1);
    localparam logic [BLINK_W-1:0] BLINK_OFF0 = BLINK_W'(BLINK_PER_MS - BLINK_OFF_MS);

    // Down-range thresholds: a strict "<" against these leaves the range.
    localparam logic [19:0] R2_DOWN = 20'(100000 - HYST);
    localparam logic [19:0] R1_DOWN = 20'(10000 - HYST);

    typedef enum logic [0:0] {
        SHOW_A = 1'b0,
        SHOW_B = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        R0 = 2'd0,
        R1 = 2'd1,
        R2 = 2'd2
    } range_t;

    // Autorange decision. Up-ranging takes effect at once. Down-ranging needs
    // the value to fall HYST counts below the range boundary. A drop can skip
    // straight from R2 to R0.
    function automatic range_t next_range(input logic [19:0] val, input range_t cur);
        range_t nr;
        nr = R0;
        if (val > 20'd99999) begin
            nr = R2;
        end else if (val > 20'd9999) begin
            if ((cur == R2) && (val >= R2_DOWN)) begin
                nr = R2;
            end else begin
                nr = R1;
            end
        end else begin
            case (cur)
                R2: begin
                    if (val < R1_DOWN) begin
                        nr = R0;
                    end else if (val < R2_DOWN) begin
                        nr = R1;
                    end else begin
                        nr = R2;
                    end
                end
                R1: begin
                    if (val < R1_DOWN) begin
                        nr = R0;
                    end else begin
                        nr = R1;
                    end
                end
                R0:      nr = R0;
                default: nr = R0;
            endcase
        end
        return nr;
    endfunction

    // Stage 1 state
    state_t              state_r;
    state_t              state_nx_s;
    range_t              range_r;
    logic [23:0]         snap_r;
    logic [15:0]         b_reg_r;
    logic [UPD_W-1:0]    upd_cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [BLINK_W-1:0]  blink_cnt_r;
    logic                snap_pulse_r;

    // Decoded events
    logic                snap_evt_s;
    logic                hold_exp_s;

    // Stage 2 inputs
    logic [15:0]         window_s;
    logic                z3_s, z2_s, z1_s;
    logic [3:0]          lzb_s;
    logic [15:0]         disp_bcd_nx_s;
    logic [3:0]          disp_blank_nx_s;
    logic [2:0]          range_led_nx_s;
    logic                blink_off_s;

    // Event decode for snapshot and hold expiry
    always_comb begin
        snap_evt_s = tick_1ms && (upd_cnt_r == UPD_LAST);
        hold_exp_s = (state_r == SHOW_B) && tick_1ms && (hold_cnt_r == HOLD_LAST);
    end

    // Arbitration FSM next-state. A request always wins over hold expiry.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            SHOW_A: begin
                if (b_req) begin
                    state_nx_s = SHOW_B;
                end else begin
                    state_nx_s = SHOW_A;
                end
            end
            SHOW_B: begin
                if (b_req) begin
                    state_nx_s = SHOW_B;
                end else if (hold_exp_s) begin
                    state_nx_s = SHOW_A;
                end else begin
                    state_nx_s = SHOW_B;
                end
            end
            default: state_nx_s = SHOW_A;
        endcase
    end

    // Arbitration FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SHOW_A;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Source A snapshot cadence and autorange. This runs in every FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_cnt_r    <= '0;
            snap_r       <= 24'h000000;
            range_r      <= R0;
            snap_pulse_r <= 1'b0;
        end else begin
            snap_pulse_r <= snap_evt_s;
            if (snap_evt_s) begin
                upd_cnt_r <= '0;
                snap_r    <= a_bcd;
                range_r   <= next_range(a_val, range_r);
            end else if (tick_1ms) begin
                upd_cnt_r <= upd_cnt_r + UPD_W'(1);
            end else begin
                upd_cnt_r <= upd_cnt_r;
            end
        end
    end

    // Source B latch, hold counter and acknowledge. b_ack is taken one stage
    // early so the requester sees it one clock after the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_reg_r    <= 16'h0000;
            hold_cnt_r <= '0;
            b_ack      <= 1'b0;
        end else begin
            b_ack <= b_req;
            if (b_req) begin
                b_reg_r    <= b_bcd;
                hold_cnt_r <= '0;
            end else if ((state_r == SHOW_B) && tick_1ms) begin
                if (hold_cnt_r == HOLD_LAST) begin
                    hold_cnt_r <= '0;
                end else begin
                    hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                end
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    // Blink phase counter. While blinking is disabled the counter is pinned
    // to 0, and this has priority over a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_r <= '0;
        end else if (!blink_en) begin
            blink_cnt_r <= '0;
        end else if (tick_1ms) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r <= '0;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
            end
        end else begin
            blink_cnt_r <= blink_cnt_r;
        end
    end

    // Range window selection over the six snapshot digits
    always_comb begin
        window_s = snap_r[15:0];
        case (range_r)
            R0:      window_s = snap_r[15:0];
            R1:      window_s = snap_r[19:4];
            R2:      window_s = snap_r[23:8];
            default: window_s = snap_r[15:0];
        endcase
    end

    // Leading-zero mask: each digit blanks only if every higher digit also
    // blanks. Digit 0 always stays lit so a zero reading still shows "0".
    always_comb begin
        z3_s  = (window_s[15:12] == 4'd0);
        z2_s  = z3_s && (window_s[11:8] == 4'd0);
        z1_s  = z2_s && (window_s[7:4] == 4'd0);
        lzb_s = {z3_s, z2_s, z1_s, 1'b0};
    end

    // Next values for the output registers
    always_comb begin
        disp_bcd_nx_s   = window_s;
        disp_blank_nx_s = 4'b0000;
        range_led_nx_s  = 3'b001;
        blink_off_s     = (blink_cnt_r >= BLINK_OFF0);

        if (state_r == SHOW_B) begin
            disp_bcd_nx_s = b_reg_r;
        end else begin
            disp_bcd_nx_s = window_s;
        end

        if (blink_off_s) begin
            disp_blank_nx_s = 4'b1111;
        end else if ((state_r == SHOW_A) && (LZB != 0)) begin
            disp_blank_nx_s = lzb_s;
        end else begin
            disp_blank_nx_s = 4'b0000;
        end

        case (range_r)
            R0:      range_led_nx_s = 3'b001;
            R1:      range_led_nx_s = 3'b010;
            R2:      range_led_nx_s = 3'b100;
            default: range_led_nx_s = 3'b001;
        endcase
    end

    // Stage 2 output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_bcd   <= 16'h0000;
            disp_blank <= 4'b0000;
            range_led  <= 3'b001;
            b_active   <= 1'b0;
            upd_strobe <= 1'b0;
        end else begin
            disp_bcd   <= disp_bcd_nx_s;
            disp_blank <= disp_blank_nx_s;
            range_led  <= range_led_nx_s;
            b_active   <= (state_r == SHOW_B);
            upd_strobe <= snap_pulse_r;
        end
    end

endmodule
